// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU run sequencer.
// Contents: default widths for item index/count, address and packet counter,
// and the sequencer state encoding.
package hpu_pkg;

  localparam int unsigned ITEM_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned PKT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MATW = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } hpu_state_e;

endpackage

// File: rtl/hpu_seq_ctrl_if.sv
// Output stream (M_AXIS) handshake as seen by the HPU sequencer.
// Signals: dst_valid (TVALID), dst_ready (TREADY), dst_last (TLAST).
// Modports: master = stream source, slave = stream sink,
// monitor = passive observer (used by hpu_seq_ctrl).
interface hpu_seq_ctrl_if;

  logic dst_valid;
  logic dst_ready;
  logic dst_last;

  modport master  (output dst_valid, output dst_last, input  dst_ready);
  modport slave   (input  dst_valid, input  dst_last, output dst_ready);
  modport monitor (input  dst_valid, input  dst_ready, input dst_last);

endinterface

// File: rtl/hpu_seq_ctrl.sv
// HPU run sequencer. A start pulse latches the job configuration, runs the
// item-memory fill phase (matw, mat_a), one settle cycle, then the run phase
// (run, last), and finishes after the final output packet.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN    clock, async active-low reset
//   start, abort, err_clr      job control
//   cfg_*                      job configuration, sampled on accepted start
//   dst                        monitored output stream handshake
//   matw, mat_a                fill phase strobe and item-memory address
//   run, last                  run phase strobe, final packet in progress
//   addr_i, addr_j, random_num latched configuration
//   pkt_cnt                    completed packets in the current job
//   busy, done, err_start      status
// All outputs are registered.
module hpu_seq_ctrl
  import hpu_pkg::*;
#(
  parameter int unsigned ITEM_W = ITEM_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PKT_W  = PKT_W_DEF
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_ngram,
  input  logic [ADDR_W-1:0] cfg_dim_words,
  input  logic [PKT_W-1:0]  cfg_pkt_num,
  input  logic              cfg_skip_matw,
  input  logic              err_clr,
  hpu_seq_ctrl_if.monitor   dst,
  output logic              matw,
  output logic              run,
  output logic              last,
  output logic [ITEM_W-1:0] mat_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic [ITEM_W-1:0] random_num,
  output logic [PKT_W-1:0]  pkt_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_start
);

  hpu_state_e        state_q, state_d;
  logic [PKT_W-1:0]  pkt_num_q, pkt_num_d;
  logic              matw_d, run_d, last_d, busy_d, done_d, err_start_d;
  logic [ITEM_W-1:0] mat_a_d, random_num_d;
  logic [ADDR_W-1:0] addr_i_d, addr_j_d;
  logic [PKT_W-1:0]  pkt_cnt_d;
  logic              pkt_end;

  assign pkt_end = dst.dst_valid & dst.dst_ready & dst.dst_last;

  always_comb begin
    state_d      = state_q;
    pkt_num_d    = pkt_num_q;
    addr_i_d     = addr_i;
    addr_j_d     = addr_j;
    random_num_d = random_num;
    pkt_cnt_d    = pkt_cnt;
    mat_a_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          addr_i_d     = cfg_dim_words;
          addr_j_d     = cfg_ngram;
          random_num_d = cfg_item_num;
          pkt_num_d    = cfg_pkt_num;
          pkt_cnt_d    = '0;
          // The skip decision is taken on this edge, so it needs no latch.
          state_d      = cfg_skip_matw ? ST_RUN : ST_MATW;
        end
      end
      ST_MATW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (mat_a == random_num) begin
          state_d = ST_GAP;
        end else begin
          mat_a_d = mat_a + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pkt_end) begin
          pkt_cnt_d = pkt_cnt + 1'b1;
          if (pkt_cnt == pkt_num_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change with the state.
    matw_d = (state_d == ST_MATW);
    run_d  = (state_d == ST_RUN);
    last_d = run_d && (pkt_cnt_d == pkt_num_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    // A start while busy wins over a same-cycle clear.
    if (start && (state_q != ST_IDLE)) begin
      err_start_d = 1'b1;
    end else if (err_clr) begin
      err_start_d = 1'b0;
    end else begin
      err_start_d = err_start;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      pkt_num_q  <= '0;
      matw       <= 1'b0;
      run        <= 1'b0;
      last       <= 1'b0;
      mat_a      <= '0;
      addr_i     <= '0;
      addr_j     <= '0;
      random_num <= '0;
      pkt_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_start  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_num_q  <= pkt_num_d;
      matw       <= matw_d;
      run        <= run_d;
      last       <= last_d;
      mat_a      <= mat_a_d;
      addr_i     <= addr_i_d;
      addr_j     <= addr_j_d;
      random_num <= random_num_d;
      pkt_cnt    <= pkt_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      err_start  <= err_start_d;
    end
  end

endmodule

// File: tb/tb_hpu_seq_ctrl.sv
// Self-checking bench for hpu_seq_ctrl: a table of per-cycle vectors plus
// hand-written sequences for long fill, backpressure, abort and async reset.
module tb_hpu_seq_ctrl;

  logic        AXIS_ACLK;
  logic        AXIS_ARESETN;
  logic        start, abort, err_clr, cfg_skip_matw;
  logic [15:0] cfg_item_num, cfg_pkt_num;
  logic [19:0] cfg_ngram, cfg_dim_words;
  logic        matw, run, last, busy, done, err_start;
  logic [15:0] mat_a, random_num, pkt_cnt;
  logic [19:0] addr_i, addr_j;

  hpu_seq_ctrl_if dif ();

  hpu_seq_ctrl dut (
    .AXIS_ACLK    (AXIS_ACLK),
    .AXIS_ARESETN (AXIS_ARESETN),
    .start        (start),
    .abort        (abort),
    .cfg_item_num (cfg_item_num),
    .cfg_ngram    (cfg_ngram),
    .cfg_dim_words(cfg_dim_words),
    .cfg_pkt_num  (cfg_pkt_num),
    .cfg_skip_matw(cfg_skip_matw),
    .err_clr      (err_clr),
    .dst          (dif.monitor),
    .matw         (matw),
    .run          (run),
    .last         (last),
    .mat_a        (mat_a),
    .addr_i       (addr_i),
    .addr_j       (addr_j),
    .random_num   (random_num),
    .pkt_cnt      (pkt_cnt),
    .busy         (busy),
    .done         (done),
    .err_start    (err_start)
  );

  initial AXIS_ACLK = 1'b0;
  always #5 AXIS_ACLK = ~AXIS_ACLK;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        start, abort, skip, clr, v, r, l;
    logic [15:0] item, pkt;
    logic        e_matw, e_run, e_last;
    logic [15:0] e_mat_a, e_pkt;
    logic        e_busy, e_done, e_err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic st, input logic ab, input logic sk, input logic cl,
                              input logic v, input logic r, input logic l,
                              input logic [15:0] it, input logic [15:0] pk,
                              input logic mw, input logic rn, input logic ls,
                              input logic [15:0] ma, input logic [15:0] pc,
                              input logic bz, input logic dn, input logic er);
    vec_t x;
    x.start = st; x.abort = ab; x.skip = sk; x.clr = cl;
    x.v = v; x.r = r; x.l = l; x.item = it; x.pkt = pk;
    x.e_matw = mw; x.e_run = rn; x.e_last = ls; x.e_mat_a = ma; x.e_pkt = pc;
    x.e_busy = bz; x.e_done = dn; x.e_err = er;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXIS_ACLK);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; abort = 1'b0; err_clr = 1'b0;
    dif.dst_valid = 1'b0; dif.dst_ready = 1'b0; dif.dst_last = 1'b0;
  endtask

  task automatic pkt_beat();
    dif.dst_valid = 1'b1; dif.dst_ready = 1'b1; dif.dst_last = 1'b1;
    tick();
    dif.dst_valid = 1'b0; dif.dst_ready = 1'b0; dif.dst_last = 1'b0;
  endtask

  // Called with the first fill cycle sampled; returns the number of matw
  // cycles and leaves the GAP cycle sampled.
  task automatic count_fill(input string tag, output int n);
    n = 0;
    while (matw && n < 300) begin
      chk($sformatf("%s_mat_a%0d", tag, n), 64'(mat_a), 64'(n));
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [37:0] act, exp;

    idle_in();
    cfg_item_num = '0; cfg_pkt_num = '0; cfg_skip_matw = 1'b0;
    cfg_ngram = '0; cfg_dim_words = '0;
    AXIS_ARESETN = 1'b0;
    #12;
    chk("reset_outputs",
        {matw, run, last, mat_a, pkt_cnt, busy, done, err_start, addr_i, addr_j, random_num},
        '0);
    @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;

    //            st ab sk cl v  r  l  item pkt   mw rn ls mat_a pc bz dn er
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 2,   1,    1, 0, 0, 0,    0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    1, 0, 0, 1,    0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    1, 0, 0, 2,    0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    0, 0, 0, 0,    0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    0, 1, 0, 0,    0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 1, 1, 0,   0,    0, 1, 1, 0,    1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 0,   0,    0, 1, 1, 0,    1, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 7,   7,    0, 1, 1, 0,    1, 1, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0,   0,    0, 1, 1, 0,    1, 1, 0, 0);
    vecs[9]  = mk(1, 0, 0, 1, 0, 0, 0, 0,   0,    0, 1, 1, 0,    1, 1, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 1, 0,   0,    0, 0, 0, 0,    2, 1, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    0, 0, 0, 0,    2, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, 0,   0,    0, 0, 0, 0,    2, 0, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, 0, 0, 9,   9,    0, 0, 0, 0,    2, 0, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 0, 0, 0, 5,   0,    0, 1, 1, 0,    0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 1, 0, 0,   0,    0, 1, 1, 0,    0, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 1, 1, 0,   0,    0, 0, 0, 0,    1, 1, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0,    0, 0, 0, 0,    1, 0, 0, 0);
    vecs[18] = mk(1, 0, 1, 0, 0, 0, 0, 4,   3,    0, 1, 0, 0,    0, 1, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, 1, 1, 0,   0,    0, 1, 0, 0,    1, 1, 0, 0);
    vecs[20] = mk(0, 1, 0, 0, 1, 1, 1, 0,   0,    0, 0, 0, 0,    1, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 1, 0,   0,    0, 0, 0, 0,    1, 0, 0, 0);

    tick();
    for (int i = 0; i < NVEC; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; err_clr = vecs[i].clr;
      cfg_skip_matw = vecs[i].skip; cfg_item_num = vecs[i].item; cfg_pkt_num = vecs[i].pkt;
      dif.dst_valid = vecs[i].v; dif.dst_ready = vecs[i].r; dif.dst_last = vecs[i].l;
      tick();
      act = {matw, run, last, mat_a, pkt_cnt, busy, done, err_start};
      exp = {vecs[i].e_matw, vecs[i].e_run, vecs[i].e_last, vecs[i].e_mat_a, vecs[i].e_pkt,
             vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end
    idle_in();
    tick();

    // Fill then run: 100 fill cycles, one gap, three packets.
    cfg_item_num = 16'd99; cfg_pkt_num = 16'd2; cfg_skip_matw = 1'b0;
    cfg_ngram = 20'h00123; cfg_dim_words = 20'h00456;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_item_num = 16'd7; cfg_pkt_num = 16'd0; cfg_ngram = 20'hfffff; cfg_dim_words = 20'h0;
    count_fill("fill", n);
    chk("fill_matw_cycles", 64'(n), 64'd100);
    chk("gap_cycle", {run, matw, busy}, 3'b001);
    chk("latched_cfg", {addr_i, addr_j, random_num}, {20'h00456, 20'h00123, 16'd99});
    tick();
    chk("run_entry", {run, last, pkt_cnt}, {2'b10, 16'd0});
    pkt_beat();
    chk("pkt1", {run, last, pkt_cnt, done}, {2'b10, 16'd1, 1'b0});
    pkt_beat();
    chk("pkt2_last", {run, last, pkt_cnt, done}, {2'b11, 16'd2, 1'b0});
    pkt_beat();
    chk("pkt3_done", {run, last, pkt_cnt, done, busy}, {2'b00, 16'd3, 2'b11});
    tick();
    chk("after_done", {done, busy, pkt_cnt, addr_i}, {2'b00, 16'd3, 20'h00456});

    // Backpressure: TLAST held without TREADY must not count.
    cfg_skip_matw = 1'b1; cfg_pkt_num = 16'd0; cfg_item_num = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    dif.dst_valid = 1'b1; dif.dst_last = 1'b1; dif.dst_ready = 1'b0;
    repeat (10) tick();
    chk("bp_hold", {run, last, pkt_cnt}, {2'b11, 16'd0});
    dif.dst_ready = 1'b1;
    tick();
    chk("bp_release", {run, pkt_cnt, done}, {1'b0, 16'd1, 1'b1});
    idle_in();
    tick();

    // Abort mid-fill, then a fresh job fills from zero.
    cfg_skip_matw = 1'b0; cfg_item_num = 16'd99; cfg_pkt_num = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mat_a != 16'd40 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reach40", {matw, mat_a}, {1'b1, 16'd40});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fill", {matw, mat_a, busy, done, run}, '0);
    tick();
    chk("abort_no_done", {done, busy}, 2'b00);
    start = 1'b1;
    tick();
    start = 1'b0;
    count_fill("refill", n);
    chk("refill_cycles", 64'(n), 64'd100);
    tick();
    chk("refill_run", {run, last}, 2'b11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run", {run, last, busy, done, pkt_cnt}, '0);

    // Async reset between edges clears outputs without a clock edge.
    cfg_skip_matw = 1'b1; cfg_pkt_num = 16'd1; cfg_dim_words = 20'h0abcd;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_reset_run", {run, busy, addr_i}, {2'b11, 20'h0abcd});
    #2;
    AXIS_ARESETN = 1'b0;
    #1;
    chk("async_reset", {run, last, busy, addr_i, random_num}, '0);
    @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;
    tick();
    chk("post_reset_idle", {run, busy, matw}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hpu_seq_ctrl.md
Name: hpu_seq_ctrl

Overview:
Run sequencer for the HPU datapath. It replaces the software-driven run/matw/last bits and the hard-wired n-gram, dimension and item-count values. One start pulse latches a job configuration, runs the item-memory fill phase (matw, mat_a), then the run phase (run, last), and ends the job on the final output packet. It sits between the AXI-Lite register block and src_ctrl, s_ctrl, exe_ctrl, out_ctrl, dst_ctrl and core.

Parameters:
ITEM_W, 16, width of item-memory index and count (mat_a, random_num)
ADDR_W, 20, width of addr_i / addr_j
PKT_W, 16, width of the output packet counter

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESETN  in  1  asynchronous active-low reset
start  in  1  job start pulse; accepted only in IDLE
abort  in  1  cancel the current job; level sampled every cycle
cfg_item_num  in  ITEM_W  last item-memory index (item count minus 1)
cfg_ngram  in  ADDR_W  n-gram depth value forwarded as addr_j
cfg_dim_words  in  ADDR_W  per-item word count minus 1, forwarded as addr_i
cfg_pkt_num  in  PKT_W  number of output packets minus 1
cfg_skip_matw  in  1  1 = skip the item-memory fill phase
err_clr  in  1  clears err_start
dst_valid, dst_ready, dst_last  in  1 each  monitored M_AXIS TVALID/TREADY/TLAST
matw  out  1  item-memory write phase
run  out  1  data run phase
last  out  1  final packet of job in progress
mat_a  out  ITEM_W  item-memory write address
addr_i, addr_j  out  ADDR_W  latched cfg_dim_words, cfg_ngram
random_num  out  ITEM_W  latched cfg_item_num
pkt_cnt  out  PKT_W  completed output packets in current job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal job completion
err_start  out  1  sticky: start seen while busy

Behaviour:
- Reset (async, AXIS_ARESETN=0): state IDLE. All outputs 0, including latched config.
- All outputs are registered. Each phase output rises on the cycle after the transition into its state.
- States: IDLE, MATW, GAP, RUN, DONE.
- IDLE:
  - start=1 and abort=0: latch every cfg_* into addr_i, addr_j, random_num and internal pkt_num/skip; clear pkt_cnt.
  - Then go to MATW, or to RUN if cfg_skip_matw=1.
  - start=1 and abort=1 in the same cycle: abort wins; stay in IDLE, no latch.
- MATW:
  - matw=1; mat_a starts at 0 and increments by 1 each cycle.
  - On the cycle with mat_a==random_num: go to GAP; mat_a returns to 0.
  - matw is high for exactly random_num+1 cycles. random_num=0 gives a 1-cycle matw.
- GAP: exactly 1 cycle with matw=run=0 (lets the xorshift/core write path settle), then RUN.
- RUN:
  - run=1.
  - pkt_cnt increments on each dst_valid & dst_ready & dst_last.
  - last = run & (pkt_cnt==pkt_num). With pkt_num=0, last=1 from the first RUN cycle.
  - A packet-end beat while pkt_cnt==pkt_num: go to DONE; pkt_cnt shows pkt_num+1 in DONE.
  - pkt_cnt wraps modulo 2^PKT_W; no saturation.
- DONE: run=last=0; done=1 for exactly this cycle; then IDLE. Latched config and pkt_cnt hold until the next accepted start.
- abort=1 in any non-IDLE state:
  - next state is IDLE; matw/run/last/mat_a go to 0 next cycle.
  - no done pulse; pkt_cnt holds.
- start while busy: ignored; err_start=1 next cycle.
- err_clr: clears err_start. A same-cycle set (start while busy) wins over err_clr.
- dst_* handshakes outside RUN are ignored.
- cfg_* changes after start have no effect until the next accepted start.

Decomposition:
- Shared package hpu_pkg: state encoding localparams (ST_IDLE..ST_DONE), default ITEM_W/ADDR_W/PKT_W.
- Single flat module. A sub-module is not warranted; the mat_a counter and pkt counter are a few lines each.

Test Plan:
- Fill then run: cfg_item_num=99, cfg_pkt_num=2, skip=0, start → matw high exactly 100 cycles with mat_a 0..99; 1 GAP cycle; run=1; last rises after the 2nd TLAST handshake; after the 3rd, done pulses once, pkt_cnt=3, busy=0.
- Skip fill: skip=1, item_num=5, pkt_num=0, start → matw never rises; run and last both rise the cycle after start; first TLAST handshake → done.
- Backpressure: in RUN hold dst_valid=1, dst_last=1, dst_ready=0 for 10 cycles → pkt_cnt stays 0; ready=1 for one cycle → pkt_cnt=1.
- Abort mid-fill: abort at mat_a=40 → next cycle matw=0, mat_a=0, busy=0, no done; a new start runs a full fill from 0.
- Start while busy: start pulse during RUN → no state change, err_start=1; err_clr → 0; start+abort in IDLE → stays IDLE, err_start=0.
- Async reset mid-RUN: AXIS_ARESETN low between clock edges → run, last, busy, addr_i=0 immediately, without waiting for a clock edge.
